// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared opcode and register constants for the instruction fetch sequencer
// and anything that builds programs for it.
package instruction_fetch_sequencer_pkg;

    localparam logic [3:0] NOP = 4'h0;
    localparam logic [3:0] STO = 4'h1;
    localparam logic [3:0] ADD = 4'h2;
    localparam logic [3:0] MUL = 4'h3;
    localparam logic [3:0] LED = 4'h4;
    localparam logic [3:0] JMP = 4'h5;

    localparam logic [7:0] R0 = 8'h00;
    localparam logic [7:0] R1 = 8'h01;
    localparam logic [7:0] R2 = 8'h02;
    localparam logic [7:0] R3 = 8'h03;

    // Instructions that the sequencer consumes itself and never issues.
    function automatic logic is_local_op(input logic [3:0] op);
        return (op == NOP) || (op == JMP);
    endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_nop_delay_counter.sv
// Loadable down-counter timing NOP stalls; stops at zero and reports it.
module nop_delay_counter #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count register: load wins over decrement, decrement saturates at zero.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (enable && !zero) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Program-memory reader: fetches from a combinational ROM, executes NOP/JMP
// locally and hands every other instruction out over valid/ready.
module instruction_fetch_sequencer
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int INSTR_W     = 28,
    parameter int DELAY_SHIFT = 0
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               iEnable,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    output logic               oValid,
    input  logic               iReady,
    output logic [3:0]         oOperation,
    output logic [7:0]         oDestination,
    output logic [7:0]         oSourceA,
    output logic [7:0]         oSourceB,
    output logic               oBusy
);

    localparam int CNT_W = 24 + DELAY_SHIFT;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        DELAY = 2'd2
    } state_e;

    state_e            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s, pc_inc_s;
    logic              valid_r, valid_s;
    logic              busy_r, busy_s;
    logic [3:0]        op_r, op_s;
    logic [7:0]        dst_r, dst_s, srca_r, srca_s, srcb_r, srcb_s;
    logic              cnt_load_s, cnt_en_s, cnt_zero_s;
    logic [23:0]       payload_s;
    logic [CNT_W-1:0]  cnt_value_s;

    assign pc_inc_s  = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign payload_s = iInstruction[23:0];
    // The counter is loaded one short so that the stall ends on the edge it hits zero.
    assign cnt_value_s = (CNT_W'(payload_s) << DELAY_SHIFT) - {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, next program counter and next output values.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        valid_s    = valid_r;
        busy_s     = busy_r;
        op_s       = op_r;
        dst_s      = dst_r;
        srca_s     = srca_r;
        srcb_s     = srcb_r;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        case (state_r)
            FETCH: begin
                if (iEnable) begin
                    if (!is_local_op(iInstruction[27:24])) begin
                        op_s    = iInstruction[27:24];
                        dst_s   = iInstruction[23:16];
                        srca_s  = iInstruction[15:8];
                        srcb_s  = iInstruction[7:0];
                        valid_s = 1'b1;
                        state_s = ISSUE;
                    end else if (iInstruction[27:24] == JMP) begin
                        pc_s = ADDR_W'(iInstruction[15:0]);
                    end else if (payload_s != 24'd0) begin
                        cnt_load_s = 1'b1;
                        busy_s     = 1'b1;
                        state_s    = DELAY;
                    end else begin
                        pc_s = pc_inc_s;
                    end
                end else begin
                    state_s = FETCH;
                end
            end
            ISSUE: begin
                if (iReady) begin
                    valid_s = 1'b0;
                    pc_s    = pc_inc_s;
                    state_s = FETCH;
                end else begin
                    valid_s = 1'b1;
                end
            end
            DELAY: begin
                cnt_en_s = 1'b1;
                if (cnt_zero_s) begin
                    busy_s  = 1'b0;
                    pc_s    = pc_inc_s;
                    state_s = FETCH;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                valid_s = 1'b0;
                busy_s  = 1'b0;
                state_s = FETCH;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= FETCH;
            pc_r    <= {ADDR_W{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            op_r    <= 4'h0;
            dst_r   <= 8'h00;
            srca_r  <= 8'h00;
            srcb_r  <= 8'h00;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            op_r    <= op_s;
            dst_r   <= dst_s;
            srca_r  <= srca_s;
            srcb_r  <= srcb_s;
        end
    end

    nop_delay_counter #(
        .WIDTH(CNT_W)
    ) u_delay (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .load       (cnt_load_s),
        .enable     (cnt_en_s),
        .load_value (cnt_value_s),
        .zero       (cnt_zero_s)
    );

    assign oAddress     = pc_r;
    assign oValid       = valid_r;
    assign oBusy        = busy_r;
    assign oOperation   = op_r;
    assign oDestination = dst_r;
    assign oSourceA     = srca_r;
    assign oSourceB     = srcb_r;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer with a program-walking
// reference model compared against the DUT on every falling clock edge.
module tb_instruction_fetch_sequencer;
    import instruction_fetch_sequencer_pkg::*;

    localparam int DS = 0;

    logic        Clock, Reset_n, iEnable, iReady;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        oValid, oBusy;
    logic [3:0]  oOperation;
    logic [7:0]  oDestination, oSourceA, oSourceB;

    logic [27:0] rom [0:65535];
    int checks = 0;
    int errors = 0;

    assign iInstruction = rom[oAddress];

    instruction_fetch_sequencer #(.ADDR_W(16), .INSTR_W(28), .DELAY_SHIFT(DS)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .iEnable(iEnable), .oAddress(oAddress),
        .iInstruction(iInstruction), .oValid(oValid), .iReady(iReady),
        .oOperation(oOperation), .oDestination(oDestination), .oSourceA(oSourceA),
        .oSourceB(oSourceB), .oBusy(oBusy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: walks the program by the instruction rules.
    logic [15:0] m_pc;
    logic        m_valid;
    int          m_busy_left;
    logic [27:0] m_word;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pc <= 16'd0; m_valid <= 1'b0; m_busy_left <= 0; m_word <= 28'd0;
        end else if (m_valid) begin
            if (iReady) begin
                m_valid <= 1'b0;
                m_pc    <= m_pc + 16'd1;
            end
        end else if (m_busy_left > 0) begin
            m_busy_left <= m_busy_left - 1;
            if (m_busy_left == 1) m_pc <= m_pc + 16'd1;
        end else if (iEnable) begin
            if (rom[m_pc][27:24] == NOP && rom[m_pc][23:0] != 24'd0)
                m_busy_left <= int'(rom[m_pc][23:0]) << DS;
            else if (rom[m_pc][27:24] == NOP)
                m_pc <= m_pc + 16'd1;
            else if (rom[m_pc][27:24] == JMP)
                m_pc <= rom[m_pc][15:0];
            else begin
                m_valid <= 1'b1;
                m_word  <= rom[m_pc];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge Clock) begin
        chk("model_addr", {16'd0, oAddress}, {16'd0, m_pc});
        chk("model_valid", {31'd0, oValid}, {31'd0, m_valid});
        chk("model_busy", {31'd0, oBusy}, {31'd0, (m_busy_left > 0)});
        chk("model_fields", {4'd0, oOperation, oDestination, oSourceA, oSourceB}, {4'd0, m_word});
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 65536; i++) rom[i] = {NOP, 24'd0};
    endtask

    task automatic hold_reset();
        Reset_n = 1'b0;
        clear_rom();
        tick();
    endtask

    task automatic release_reset();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic measure_busy(input string name, input int exp_len, input logic [15:0] exp_addr);
        int n;
        bit saw_valid;
        n = 0;
        saw_valid = 1'b0;
        tick();
        while (oBusy && n < 5000) begin
            n++;
            if (oValid) saw_valid = 1'b1;
            tick();
        end
        iEnable = 1'b0;
        chk({name, "_len"}, n, exp_len);
        chk({name, "_novalid"}, {31'd0, saw_valid}, 32'd0);
        chk({name, "_addr"}, {16'd0, oAddress}, {16'd0, exp_addr});
    endtask

    initial begin
        Reset_n = 1'b0; iEnable = 1'b0; iReady = 1'b0;
        clear_rom();
        #1;
        chk("reset_addr", {16'd0, oAddress}, 32'd0);
        chk("reset_valid", {31'd0, oValid}, 32'd0);
        chk("reset_busy", {31'd0, oBusy}, 32'd0);

        // STO accepted immediately
        hold_reset();
        rom[0] = {STO, R0, 16'd465};
        iEnable = 1'b1; iReady = 1'b1;
        release_reset();
        tick();
        chk("sto_valid", {31'd0, oValid}, 32'd1);
        chk("sto_op", {28'd0, oOperation}, {28'd0, STO});
        chk("sto_dst", {24'd0, oDestination}, {24'd0, R0});
        chk("sto_imm", {16'd0, oSourceA, oSourceB}, 32'd465);
        tick();
        iEnable = 1'b0;
        chk("sto_accept_addr", {16'd0, oAddress}, 32'd1);
        chk("sto_accept_valid", {31'd0, oValid}, 32'd0);

        // MUL stalled by iReady, iEnable dropped while issuing
        hold_reset();
        rom[0] = {MUL, R3, 8'h12, 8'h34};
        iEnable = 1'b1; iReady = 1'b0;
        release_reset();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mul_hold_valid", {31'd0, oValid}, 32'd1);
            chk("mul_hold_fields", {4'd0, oOperation, oDestination, oSourceA, oSourceB},
                {4'd0, MUL, R3, 8'h12, 8'h34});
            chk("mul_hold_addr", {16'd0, oAddress}, 32'd0);
        end
        iReady = 1'b1; iEnable = 1'b0;
        tick();
        chk("mul_accept_valid", {31'd0, oValid}, 32'd0);
        chk("mul_accept_addr", {16'd0, oAddress}, 32'd1);
        repeat (3) tick();
        chk("mul_single_accept", {16'd0, oAddress}, 32'd1);

        // NOP stall of 4000 cycles
        hold_reset();
        rom[0] = {NOP, 24'd4000};
        iEnable = 1'b1;
        release_reset();
        measure_busy("nop4000", 4000, 16'd1);

        // JMP and zero-payload NOP, JMP ignores bits [23:16]
        hold_reset();
        rom[0] = {JMP, 8'hAB, 16'd5};
        rom[7] = {JMP, 8'd0, 16'd0};
        iEnable = 1'b1;
        release_reset();
        tick(); chk("jmp_to5", {16'd0, oAddress}, 32'd5);
        tick(); chk("nop0_to6", {16'd0, oAddress}, 32'd6);
        tick(); chk("nop0_to7", {16'd0, oAddress}, 32'd7);
        tick(); chk("jmp_to0", {16'd0, oAddress}, 32'd0);
        chk("jmp_novalid", {31'd0, oValid}, 32'd0);
        iEnable = 1'b0;

        // Asynchronous reset mid-ISSUE
        hold_reset();
        rom[0]  = {JMP, 8'd0, 16'h0010};
        rom[16] = {ADD, R2, 8'h55, 8'hAA};
        iEnable = 1'b1; iReady = 1'b0;
        release_reset();
        tick(); tick();
        chk("issue_pre_valid", {31'd0, oValid}, 32'd1);
        chk("issue_pre_addr", {16'd0, oAddress}, 32'h10);
        #2 Reset_n = 1'b0;
        #1;
        chk("areset_issue_valid", {31'd0, oValid}, 32'd0);
        chk("areset_issue_addr", {16'd0, oAddress}, 32'd0);
        chk("areset_issue_fields", {4'd0, oOperation, oDestination, oSourceA, oSourceB}, 32'd0);
        release_reset();
        tick(); chk("restart_addr", {16'd0, oAddress}, 32'h10);
        tick(); chk("restart_op", {28'd0, oOperation}, {28'd0, ADD});

        // Asynchronous reset mid-DELAY, stall restarts in full
        hold_reset();
        rom[0] = {NOP, 24'd50};
        iEnable = 1'b1; iReady = 1'b1;
        release_reset();
        repeat (10) tick();
        chk("delay_pre_busy", {31'd0, oBusy}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("areset_delay_busy", {31'd0, oBusy}, 32'd0);
        chk("areset_delay_addr", {16'd0, oAddress}, 32'd0);
        release_reset();
        measure_busy("nop50", 50, 16'd1);

        // PC wrap at 16'hFFFF and indefinite hold with iEnable low
        hold_reset();
        rom[0]     = {JMP, 8'd0, 16'hFFFF};
        rom[65535] = {LED, R1, 8'h0F, 8'hF0};
        iEnable = 1'b1; iReady = 1'b1;
        release_reset();
        tick(); chk("wrap_jmp", {16'd0, oAddress}, 32'hFFFF);
        tick(); chk("wrap_valid", {31'd0, oValid}, 32'd1);
        iEnable = 1'b0;
        tick(); chk("wrap_addr", {16'd0, oAddress}, 32'd0);
        repeat (20) tick();
        chk("hold_addr", {16'd0, oAddress}, 32'd0);
        chk("hold_valid", {31'd0, oValid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_sequencer.md
# instruction_fetch_sequencer

Program-memory reader for the Spartan-3E test cores. Drives the 16-bit address into the combinational instruction ROM, captures the returned 28-bit instruction word and splits it into opcode and operand fields. Each executable instruction is handed to the execution unit over a valid/ready handshake. NOP delays and JMP are handled locally, so the execution unit never sees them.

## Interface
Parameters:
- ADDR_W, 16, program-counter / ROM address width
- INSTR_W, 28, instruction word width: opcode[27:24], destination[23:16], sourceA[15:8], sourceB[7:0]
- DELAY_SHIFT, 0, NOP payload is left-shifted by this amount to give the stall length in cycles

Ports:
- Clock  in  1  single system clock; all state updates on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- iEnable  in  1  run control; when low, no new fetch is started
- oAddress  out  ADDR_W  ROM address, equal to the program counter
- iInstruction  in  INSTR_W  ROM data; combinational function of oAddress
- oValid  out  1  decoded instruction available to the execution unit
- iReady  in  1  execution unit accepts the instruction on this edge
- oOperation  out  4  opcode field
- oDestination  out  8  destination field
- oSourceA  out  8  sourceA field (STO immediate [15:8])
- oSourceB  out  8  sourceB field (STO immediate [7:0])
- oBusy  out  1  high while a NOP delay is running

## Operation
- States: FETCH, ISSUE, DELAY. Reset state is FETCH.
- Reset values: PC=0, oAddress=0, oValid=0, oBusy=0, all field outputs 0, delay counter 0.
- FETCH, iEnable=0: hold all state.
- FETCH, iEnable=1: decode iInstruction at the edge:
  - `NOP` with payload P = iInstruction[23:0] nonzero: load counter with P<<DELAY_SHIFT, set oBusy=1, go to DELAY. Nothing is issued.
  - `NOP` with P=0: PC<=PC+1, stay in FETCH.
  - `JMP`: PC<=iInstruction[15:0], stay in FETCH. Nothing is issued. Bits [23:16] are ignored.
  - Any other opcode (`STO`, `MUL`, `LED`, `ADD`, ...): register the four fields, oValid<=1, go to ISSUE.
- ISSUE: oValid and all field outputs are held stable until an edge with iReady=1. On that edge: oValid<=0, PC<=PC+1, go to FETCH. iEnable is ignored in ISSUE.
- DELAY: the counter decrements every cycle regardless of iEnable. On the edge where the counter reaches 0: oBusy<=0, PC<=PC+1, go to FETCH.
- PC arithmetic is modulo 2^ADDR_W; 16'hFFFF+1 wraps to 0.
- Unknown or default ROM words are treated as ordinary issuable instructions.

## Timing
- oAddress is a registered copy of PC; the ROM path is combinational, so iInstruction is sampled in the same cycle.
- Minimum cost per issued instruction: 2 cycles (FETCH, then ISSUE with iReady=1).
- JMP and zero-payload NOP: 1 cycle each.
- NOP with payload P: 1 + (P<<DELAY_SHIFT) cycles. oBusy is high for exactly P<<DELAY_SHIFT cycles.
- oValid rises on the edge that leaves FETCH. The handshake completes on the first edge where oValid=1 and iReady=1. iReady has no combinational path to any output.
- Reset_n low clears all state immediately, including mid-ISSUE (oValid drops without a handshake) and mid-DELAY. The first fetch happens on the first rising edge after Reset_n is released.

## Structure
- Opcode and register constants (`NOP`, `STO`, `JMP`, `MUL`, `LED`, `R0`...) come from the existing shared definitions header. The state encodings are local parameters of this block.
- Natural sub-module: nop_delay_counter, a 24+DELAY_SHIFT-bit loadable down-counter with load, enable and zero outputs.

## Test plan
- Reset, then ROM[0]={STO,R0,16'd465}, iReady=1: oValid=1 on the 1st edge after release, with oOperation=STO, oDestination=R0 and {oSourceA,oSourceB}=465. On the 2nd edge the instruction is accepted and oAddress=1.
- MUL issued with iReady held 0 for 5 cycles: oValid and all fields stay constant and oAddress stays unchanged. Raising iReady gives one acceptance, then oAddress advances by 1.
- ROM[0]={NOP,24'd4000}, DELAY_SHIFT=0: oBusy is high for exactly 4000 cycles, oValid never rises, then oAddress=1.
- ROM[7]={JMP,8'd0,16'd0}: the next cycle has oAddress=0 and no oValid pulse. ROM[5]={NOP,24'd0} advances in a single cycle.
- Reset_n pulsed low mid-ISSUE and again mid-DELAY: oValid, oBusy, oAddress and the fields go to 0 asynchronously, and fetch restarts at address 0.
- PC=16'hFFFF with a non-JMP instruction: after acceptance, oAddress=0. With iEnable=0 in FETCH, oAddress is held indefinitely.
